// File: rtl/word_set_pkg.sv
// Shared definitions for the word-set sequencer: state encoding and default width.
package word_set_pkg;

    localparam int unsigned N_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mult_step_unit.sv
// One shift-and-add step: gate the multiplicand, add it to the high half, shift right with carry.
module mult_step_unit #(
    parameter int unsigned N = 4
) (
    input  logic           i_bit_enable,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_acc_hi,
    input  logic [N-1:1]   i_acc_lo,
    output logic [2*N-1:0] o_acc_next
);

    logic [N-1:0] w_addend;
    logic [N:0]   w_sum;

    // acc_lo[0] falls off the end of the shift, so it is never routed in
    assign w_addend   = i_bit_enable ? i_a : '0;
    assign w_sum      = {1'b0, i_acc_hi} + {1'b0, w_addend};
    assign o_acc_next = {w_sum, i_acc_lo};

endmodule

// File: rtl/word_set_sequencer.sv
// Serial shift-and-add multiplier controller: one multiplier bit per cycle, done pulse with 2N-bit product.
module word_set_sequencer
    import word_set_pkg::*;
#(
    parameter  int unsigned N  = N_DEFAULT,
    localparam int unsigned CW = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   wordIn1,
    input  logic [N-1:0]   wordIn2,
    output logic           busy,
    output logic           done,
    output logic           bitEnable,
    output logic [CW-1:0]  stepCount,
    output logic [2*N-1:0] product
);

    state_t         r_state;
    state_t         w_state_next;
    logic           r_busy;
    logic           w_busy_next;
    logic           r_done;
    logic           w_done_next;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    // bit 0 of the accumulator only matters on the final step, where it goes straight to product
    logic [2*N-1:1] r_acc;
    logic [CW-1:0]  r_step;
    logic [2*N-1:0] r_product;
    logic [2*N-1:0] w_acc_next;
    logic           w_accept;
    logic           w_running;
    logic           w_last;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_running = (r_state == ST_RUN);
    assign w_last    = (r_step == CW'(N - 1));

    mult_step_unit #(.N(N)) u_step (
        .i_bit_enable (r_b[0]),
        .i_a          (r_a),
        .i_acc_hi     (r_acc[2*N-1:N]),
        .i_acc_lo     (r_acc[N-1:1]),
        .o_acc_next   (w_acc_next)
    );

    // Next-state and registered-output decode
    always_comb begin
        w_state_next = r_state;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_busy_next  = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                    w_done_next  = 1'b1;
                end else begin
                    w_busy_next  = 1'b1;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_step    <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            if (w_accept) begin
                r_a    <= wordIn1;
                r_b    <= wordIn2;
                r_acc  <= '0;
                r_step <= '0;
            end else if (w_running) begin
                r_acc  <= w_acc_next[2*N-1:1];
                r_b    <= r_b >> 1;
                r_step <= r_step + CW'(1);
                if (w_last) begin
                    r_product <= w_acc_next;
                end
            end
        end
    end

    // r_b is fully shifted out by DONE, so gating with busy also covers IDLE/DONE
    assign busy      = r_busy;
    assign done      = r_done;
    assign bitEnable = r_busy & r_b[0];
    assign stepCount = r_step;
    assign product   = r_product;

endmodule
